uart_tx_msg_seq: RTL and testbench

- Controller that sequences the UART transmitter. It sends a fixed multi-byte message each time it gets a one-cycle start pulse, normally `tx_send` from the debounced button.
- Byte handoff to the UART TX datapath uses a start-pulse/busy handshake.
- Enforces a programmable inter-byte gap.
- Aborts with an error pulse if the transmitter never acknowledges a byte.

---
 rtl/uart_tx_msg_seq.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_msg_seq.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_msg_seq.sv
// uart_tx_msg_seq: sends a fixed MSG_LEN-byte message to a UART TX datapath
// on each start pulse. Every byte is handed over with a tx_start pulse and
// acknowledged by tx_busy rising and then falling. A programmable idle gap can
// be inserted between bytes. If tx_busy never rises, the message is aborted
// and err is pulsed.
module uart_tx_msg_seq #(
    parameter int unsigned          MSG_LEN     = 4,
    parameter logic [MSG_LEN*8-1:0] MSG         = 32'h4849210A,
    parameter int unsigned          GAP_CYCLES  = 0,
    parameter int unsigned          ACK_TIMEOUT = 16
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       start,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       seq_busy,
    output logic [7:0] byte_idx,
    output logic       done,
    output logic       err
);

    localparam int AW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [AW-1:0] ACK_LAST = AW'(ACK_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [7:0]    LAST_IDX = 8'(MSG_LEN - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic            seq_busy_q, seq_busy_d;
    logic [7:0]      byte_idx_q, byte_idx_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic [AW-1:0]   ack_cnt_q, ack_cnt_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;

    logic            launch;
    logic [7:0]      launch_idx;

    // Byte 0 sits in the most significant byte of MSG.
    function automatic logic [7:0] msg_byte(input logic [7:0] idx);
        logic [MSG_LEN*8-1:0] sh;
        sh = MSG >> {(LAST_IDX - idx), 3'b000};
        return sh[7:0];
    endfunction

    // Next-state and output logic; a byte launch is shared by IDLE, WAIT_DONE and GAP.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        seq_busy_d = seq_busy_q;
        byte_idx_d = byte_idx_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        ack_cnt_d  = ack_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        launch     = 1'b0;
        launch_idx = byte_idx_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    launch     = 1'b1;
                    launch_idx = 8'd0;
                    seq_busy_d = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (ack_cnt_q == ACK_LAST) begin
                    // tx_data/byte_idx keep the failing byte for debug
                    err_d      = 1'b1;
                    seq_busy_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    ack_cnt_d = ack_cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                // No timeout here: a stuck-busy UART parks the sequencer.
                if (!tx_busy) begin
                    if (byte_idx_q == LAST_IDX) begin
                        done_d     = 1'b1;
                        seq_busy_d = 1'b0;
                        state_d    = IDLE;
                    end else if (GAP_CYCLES == 0) begin
                        launch = 1'b1;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    launch = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = IDLE;
                seq_busy_d = 1'b0;
            end
        endcase

        if (launch) begin
            tx_data_d  = msg_byte(launch_idx);
            tx_start_d = 1'b1;
            byte_idx_d = launch_idx;
            ack_cnt_d  = '0;
            state_d    = WAIT_ACK;
        end
    end

    // State and registered outputs; reset aborts any message in flight.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            tx_data_q  <= 8'd0;
            tx_start_q <= 1'b0;
            seq_busy_q <= 1'b0;
            byte_idx_q <= 8'd0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            ack_cnt_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            seq_busy_q <= seq_busy_d;
            byte_idx_q <= byte_idx_d;
            done_q     <= done_d;
            err_q      <= err_d;
            ack_cnt_q  <= ack_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign seq_busy = seq_busy_q;
    assign byte_idx = byte_idx_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_uart_tx_msg_seq.sv
// Bench for uart_tx_msg_seq: three instances (default, GAP_CYCLES=3, and
// MSG_LEN=1) each driven by a small UART model that raises busy one cycle
// after tx_start and holds it for 10 cycles.
module tb_uart_tx_msg_seq;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic       start_v    [3];
    logic       busy_v     [3];
    logic       tx_start_v [3];
    logic       seq_busy_v [3];
    logic       done_v     [3];
    logic       err_v      [3];
    logic [7:0] tx_data_v  [3];
    logic [7:0] byte_idx_v [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // UART model controls: launch number to ignore (0 = none)
    int ign_at     [3] = '{0, 0, 0};
    int launch_cnt [3] = '{0, 0, 0};

    logic [7:0] exp_msg [4] = '{8'h48, 8'h49, 8'h21, 8'h0A};

    // collected observations
    int         n_st, n_done, n_err, done_cyc, done_fall, err_cyc, last_fall, sb_bad;
    logic [7:0] st_data [8];
    logic [7:0] st_idx  [8];
    int         st_cyc  [8];
    int         st_fall [8];
    logic [7:0] err_idx, err_data;
    logic       err_sb;

    uart_tx_msg_seq dut0 (
        .clock(clock), .rst(rst), .start(start_v[0]), .tx_busy(busy_v[0]),
        .tx_data(tx_data_v[0]), .tx_start(tx_start_v[0]), .seq_busy(seq_busy_v[0]),
        .byte_idx(byte_idx_v[0]), .done(done_v[0]), .err(err_v[0])
    );

    uart_tx_msg_seq #(.GAP_CYCLES(3)) dut1 (
        .clock(clock), .rst(rst), .start(start_v[1]), .tx_busy(busy_v[1]),
        .tx_data(tx_data_v[1]), .tx_start(tx_start_v[1]), .seq_busy(seq_busy_v[1]),
        .byte_idx(byte_idx_v[1]), .done(done_v[1]), .err(err_v[1])
    );

    uart_tx_msg_seq #(.MSG_LEN(1), .MSG(8'h55)) dut2 (
        .clock(clock), .rst(rst), .start(start_v[2]), .tx_busy(busy_v[2]),
        .tx_data(tx_data_v[2]), .tx_start(tx_start_v[2]), .seq_busy(seq_busy_v[2]),
        .byte_idx(byte_idx_v[2]), .done(done_v[2]), .err(err_v[2])
    );

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc = cyc + 1;
    end

    // UART models: busy high from 1 cycle after tx_start for 10 cycles
    for (genvar g = 0; g < 3; g++) begin : g_uart
        initial begin
            busy_v[g] = 1'b0;
            forever begin
                @(posedge clock); #1;
                if (!rst && tx_start_v[g]) begin
                    launch_cnt[g] = launch_cnt[g] + 1;
                    if (launch_cnt[g] != ign_at[g]) begin
                        @(posedge clock); #1;
                        busy_v[g] = 1'b1;
                        repeat (10) @(posedge clock);
                        #1;
                        busy_v[g] = 1'b0;
                    end
                end
            end
        end
    end

    // Pulse start on instance d, then record launches/done/err for ncyc cycles.
    task automatic collect(input int d, input int ncyc);
        logic pb;
        n_st = 0; n_done = 0; n_err = 0; done_cyc = -1; done_fall = -1;
        err_cyc = -1; last_fall = -1; sb_bad = 0;
        err_idx = 8'hxx; err_data = 8'hxx; err_sb = 1'bx;
        @(negedge clock);
        start_v[d] = 1'b1;
        pb = busy_v[d];
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clock);
            start_v[d] = 1'b0;
            if (pb && !busy_v[d]) last_fall = cyc;
            pb = busy_v[d];
            if (tx_start_v[d]) begin
                if (n_st < 8) begin
                    st_data[n_st] = tx_data_v[d];
                    st_idx[n_st]  = byte_idx_v[d];
                    st_cyc[n_st]  = cyc;
                    st_fall[n_st] = last_fall;
                end
                n_st++;
            end
            if (done_v[d]) begin
                n_done++; done_cyc = cyc; done_fall = last_fall;
            end
            if (err_v[d]) begin
                n_err++; err_cyc = cyc;
                err_idx = byte_idx_v[d]; err_data = tx_data_v[d]; err_sb = seq_busy_v[d];
            end
            if (n_st > 0 && n_done == 0 && n_err == 0 && !seq_busy_v[d]) sb_bad++;
            if ((done_v[d] || err_v[d]) && seq_busy_v[d]) sb_bad++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (tx_data_v[d] !== 8'h00 || tx_start_v[d] !== 1'b0 || seq_busy_v[d] !== 1'b0 ||
                byte_idx_v[d] !== 8'h00 || done_v[d] !== 1'b0 || err_v[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: data=%h start=%b busy=%b idx=%h done=%b err=%b, want all 0",
                         d, tx_data_v[d], tx_start_v[d], seq_busy_v[d], byte_idx_v[d], done_v[d], err_v[d]);
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_basic;
        collect(0, 70);
        checks++;
        if (n_st !== 4) begin errors++; $display("FAIL basic_nbytes got %0d want 4", n_st); end
        for (int k = 0; k < 4 && k < n_st; k++) begin
            checks++;
            if (st_data[k] !== exp_msg[k] || st_idx[k] !== 8'(k)) begin
                errors++;
                $display("FAIL basic_byte%0d got %h idx %0d want %h idx %0d", k, st_data[k], st_idx[k], exp_msg[k], k);
            end
            if (k > 0) begin
                checks++;
                if (st_cyc[k] - st_fall[k] !== 1) begin
                    errors++;
                    $display("FAIL basic_spacing%0d got %0d want 1", k, st_cyc[k] - st_fall[k]);
                end
            end
        end
        checks++;
        if (n_done !== 1 || n_err !== 0) begin
            errors++; $display("FAIL basic_done got done=%0d err=%0d want 1/0", n_done, n_err);
        end
        checks++;
        if (done_cyc - done_fall !== 1) begin
            errors++; $display("FAIL basic_done_lat got %0d want 1", done_cyc - done_fall);
        end
        checks++;
        if (sb_bad !== 0 || seq_busy_v[0] !== 1'b0) begin
            errors++; $display("FAIL basic_seq_busy got %0d bad cycles, end=%b want 0/0", sb_bad, seq_busy_v[0]);
        end
    endtask

    task automatic test_gap;
        collect(1, 100);
        checks++;
        if (n_st !== 4) begin errors++; $display("FAIL gap_nbytes got %0d want 4", n_st); end
        for (int k = 0; k < 4 && k < n_st; k++) begin
            checks++;
            if (st_data[k] !== exp_msg[k]) begin
                errors++; $display("FAIL gap_byte%0d got %h want %h", k, st_data[k], exp_msg[k]);
            end
            if (k > 0) begin
                // busy=0 first sampled one edge after fall; launch 3 cycles later
                checks++;
                if (st_cyc[k] - st_fall[k] !== 4) begin
                    errors++; $display("FAIL gap_spacing%0d got %0d want 4", k, st_cyc[k] - st_fall[k]);
                end
            end
        end
        checks++;
        if (n_done !== 1 || done_cyc - done_fall !== 1 || sb_bad !== 0) begin
            errors++;
            $display("FAIL gap_done got n=%0d lat=%0d sb_bad=%0d want 1/1/0", n_done, done_cyc - done_fall, sb_bad);
        end
    endtask

    task automatic test_timeout;
        launch_cnt[0] = 0;
        ign_at[0] = 2;
        collect(0, 60);
        ign_at[0] = 0;
        checks++;
        if (n_st !== 2 || st_data[1] !== 8'h49) begin
            errors++; $display("FAIL to_launches got n=%0d byte1=%h want 2/49", n_st, st_data[1]);
        end
        checks++;
        if (n_err !== 1 || err_cyc - st_cyc[1] !== 16) begin
            errors++; $display("FAIL to_err got n=%0d lat=%0d want 1/16", n_err, err_cyc - st_cyc[1]);
        end
        checks++;
        if (err_idx !== 8'd1 || err_data !== 8'h49 || err_sb !== 1'b0) begin
            errors++; $display("FAIL to_debug got idx=%h data=%h sb=%b want 01/49/0", err_idx, err_data, err_sb);
        end
        checks++;
        if (n_done !== 0 || sb_bad !== 0) begin
            errors++; $display("FAIL to_nodone got done=%0d sb_bad=%0d want 0/0", n_done, sb_bad);
        end
    endtask

    task automatic test_back_to_back;
        int n, nd, mid_at, fresh_at, done1_cyc, fresh_cyc, n_at_done1;
        logic pb;
        logic [7:0] d [8];
        n = 0; nd = 0; mid_at = -1; fresh_at = -1; done1_cyc = -1; fresh_cyc = -1; n_at_done1 = -1;
        pb = busy_v[0];
        @(negedge clock);
        start_v[0] = 1'b1;
        for (int i = 0; i < 160; i++) begin
            @(negedge clock);
            start_v[0] = 1'b0;
            if (tx_start_v[0]) begin
                if (n < 8) d[n] = tx_data_v[0];
                if (n == 4) fresh_cyc = cyc;
                n++;
                if (n == 2) mid_at = cyc + 3;
            end
            if (cyc == mid_at) start_v[0] = 1'b1;
            // busy fell on byte 4: the next edge is the done edge
            if (pb && !busy_v[0] && n == 4 && nd == 0) start_v[0] = 1'b1;
            pb = busy_v[0];
            if (done_v[0]) begin
                nd++;
                if (nd == 1) begin done1_cyc = cyc; fresh_at = cyc + 1; n_at_done1 = n; end
            end
            if (cyc == fresh_at) start_v[0] = 1'b1;
        end
        checks++;
        if (n_at_done1 !== 4) begin errors++; $display("FAIL b2b_first_msg got %0d bytes want 4", n_at_done1); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (d[k] !== exp_msg[k]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", k, d[k], exp_msg[k]); end
        end
        checks++;
        if (d[4] !== 8'h48 || fresh_cyc - done1_cyc !== 2) begin
            errors++; $display("FAIL b2b_fresh got %h at +%0d want 48 at +2", d[4], fresh_cyc - done1_cyc);
        end
        checks++;
        if (n !== 8 || nd !== 2) begin errors++; $display("FAIL b2b_totals got bytes=%0d done=%0d want 8/2", n, nd); end
    endtask

    task automatic test_async_reset;
        int n, k, bad;
        n = 0; k = 0; bad = 0;
        @(negedge clock);
        start_v[0] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            start_v[0] = 1'b0;
            if (tx_start_v[0]) n++;
            if (n == 3 && busy_v[0]) k++;
            if (k == 3) break;
        end
        checks++;
        if (k !== 3) begin errors++; $display("FAIL rst_reach_byte3 got n=%0d k=%0d want 3/3", n, k); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (tx_data_v[0] !== 8'h00 || tx_start_v[0] !== 1'b0 || seq_busy_v[0] !== 1'b0 ||
            byte_idx_v[0] !== 8'h00 || done_v[0] !== 1'b0 || err_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL rst_async got data=%h start=%b busy=%b idx=%h done=%b err=%b want all 0",
                     tx_data_v[0], tx_start_v[0], seq_busy_v[0], byte_idx_v[0], done_v[0], err_v[0]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (done_v[0] || err_v[0] || seq_busy_v[0]) bad++;
        end
        rst = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            if (done_v[0] || err_v[0] || seq_busy_v[0]) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rst_quiet got %0d active cycles want 0", bad); end
        collect(0, 70);
        checks++;
        if (n_st !== 4 || n_done !== 1 || n_err !== 0) begin
            errors++; $display("FAIL rst_resend got bytes=%0d done=%0d err=%0d want 4/1/0", n_st, n_done, n_err);
        end
        for (int j = 0; j < 4 && j < n_st; j++) begin
            checks++;
            if (st_data[j] !== exp_msg[j]) begin
                errors++; $display("FAIL rst_byte%0d got %h want %h", j, st_data[j], exp_msg[j]);
            end
        end
    endtask

    task automatic test_single_byte;
        collect(2, 40);
        checks++;
        if (n_st !== 1 || st_data[0] !== 8'h55 || st_idx[0] !== 8'h00) begin
            errors++; $display("FAIL single_byte got n=%0d data=%h idx=%h want 1/55/00", n_st, st_data[0], st_idx[0]);
        end
        checks++;
        if (n_done !== 1 || done_cyc - done_fall !== 1 || sb_bad !== 0) begin
            errors++;
            $display("FAIL single_done got n=%0d lat=%0d sb_bad=%0d want 1/1/0", n_done, done_cyc - done_fall, sb_bad);
        end
    endtask

    initial begin
        for (int d = 0; d < 3; d++) start_v[d] = 1'b0;
        test_reset;
        test_basic;
        test_gap;
        test_timeout;
        test_back_to_back;
        test_async_reset;
        test_single_byte;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
